// File: rtl/half_adder.sv
// Bit-parallel half adder with optional output register stage and a saturating
// counter of accepted operations that produced any carry.
module half_adder #(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  assign sum_c   = a ^ b;
  assign carry_c = a & b;

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] sum_q;
      logic [WIDTH-1:0] carry_q;
      logic             valid_q;

      // Operands only load when qualified, so idle-cycle garbage never lands here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q   <= '0;
          carry_q <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= in_valid;
          if (in_valid) begin
            sum_q   <= sum_c;
            carry_q <= carry_c;
          end
        end
      end

      assign sum       = sum_q;
      assign carry     = carry_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign sum       = sum_c;
      assign carry     = carry_c;
      assign out_valid = in_valid;
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             carry_evt;

  assign carry_evt = in_valid & (|carry_c);

  // Clear wins over a same-cycle increment; the count sticks at its maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (carry_evt && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: scoreboarded random traffic on an 8-lane registered
// instance, plus directed checks on a 1-lane/2-bit-counter and a combinational one.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v1, clr1, ov1;
  logic [7:0] a1, b1, s1, c1;
  logic [15:0] cnt1;

  logic       v2, clr2, ov2;
  logic [0:0] a2, b2, s2, c2;
  logic [1:0] cnt2;

  logic       v3, clr3, ov3;
  logic [3:0] a3, b3, s3, c3;
  logic [15:0] cnt3;

  half_adder #(.WIDTH(8), .REGISTERED(1'b1), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cnt_clr(clr1),
    .sum(s1), .carry(c1), .out_valid(ov1), .carry_cnt(cnt1)
  );

  half_adder #(.WIDTH(1), .REGISTERED(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .cnt_clr(clr2),
    .sum(s2), .carry(c2), .out_valid(ov2), .carry_cnt(cnt2)
  );

  half_adder #(.WIDTH(4), .REGISTERED(1'b0), .CNT_W(16)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .a(a3), .b(b3), .cnt_clr(clr3),
    .sum(s3), .carry(c3), .out_valid(ov3), .carry_cnt(cnt3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] c;
  } res_t;

  res_t        exp_q[$];
  logic [7:0]  last_s = '0;
  logic [7:0]  last_c = '0;
  int unsigned exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected result is due at the falling edge after it was captured.
  always @(negedge clk) begin
    res_t r;
    check("main_out_valid", ov1, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check("main_sum", s1, r.s);
      check("main_carry", c1, r.c);
      last_s = r.s;
      last_c = r.c;
    end else if (!ov1) begin
      check("main_hold_sum", s1, last_s);
      check("main_hold_carry", c1, last_c);
    end
    check("main_carry_cnt", cnt1, exp_cnt);
  end

  // Drive one cycle on the main instance; reference model updates at the edge.
  task automatic op1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic clr);
    v1   = v;
    a1   = a;
    b1   = b;
    clr1 = clr;
    @(posedge clk);
    if (rst_n) begin
      if (v) exp_q.push_back('{s: a ^ b, c: a & b});
      if (clr) exp_cnt = 0;
      else if (v && ((a & b) != 0) && (exp_cnt < 65535)) exp_cnt++;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ra, rb;
    rst_n = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; clr1 = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0; clr2 = 1'b0;
    v3 = 1'b0; a3 = 4'hA; b3 = 4'h6; clr3 = 1'b0;

    #2;
    check("rst_sum", s1, 8'h00);
    check("rst_carry", c1, 8'h00);
    check("rst_out_valid", ov1, 1'b0);
    check("rst_cnt", cnt1, 16'd0);
    check("rst_comb_sum", s3, 4'hC);
    check("rst_comb_carry", c3, 4'h2);
    #10;
    rst_n = 1'b1;
    tick();

    // Truth table on a single lane, one cycle latency.
    for (int i = 0; i < 4; i++) begin
      a2 = (i >= 2);
      b2 = (i % 2 == 1);
      v2 = 1'b1;
      tick();
      check("tt_sum", s2, (i == 1) || (i == 2));
      check("tt_carry", c2, i == 3);
      check("tt_out_valid", ov2, 1'b1);
    end
    v2 = 1'b0;
    tick();
    check("tt_idle_valid", ov2, 1'b0);
    check("tt_hold_carry", c2, 1'b1);
    check("sat_cnt_start", cnt2, 2'd1);
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    check("sat_clr", cnt2, 2'd0);
    a2 = 1'b1;
    b2 = 1'b1;
    v2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("sat_cnt", cnt2, (k > 3) ? 3 : k);
    end
    clr2 = 1'b1;
    tick();
    check("sat_clr_priority", cnt2, 2'd0);
    clr2 = 1'b0;
    tick();
    check("sat_cnt_after_clr", cnt2, 2'd1);
    v2 = 1'b0;

    // Combinational variant: no clock edge needed.
    a3 = 4'h1;
    b3 = 4'h1;
    v3 = 1'b0;
    #1;
    check("comb_sum", s3, 4'h0);
    check("comb_carry", c3, 4'h1);
    check("comb_out_valid0", ov3, 1'b0);
    v3 = 1'b1;
    #1;
    check("comb_out_valid1", ov3, 1'b1);
    v3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      a3 = ra;
      b3 = rb;
      #1;
      check("comb_rand_sum", s3, ra ^ rb);
      check("comb_rand_carry", c3, ra & rb);
    end
    tick();

    // Directed multi-lane op followed by idle cycles that must hold the result.
    op1(1'b1, 8'hF0, 8'hCC, 1'b0);
    check("f0cc_sum", s1, 8'h3C);
    check("f0cc_carry", c1, 8'hC0);
    check("f0cc_cnt", cnt1, 16'd1);
    for (int k = 0; k < 3; k++) op1(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    check("f0cc_hold_sum", s1, 8'h3C);

    for (int k = 0; k < 300; k++) begin
      op1($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
    end

    // Reset asserted mid-stream between edges.
    op1(1'b1, 8'hFF, 8'h01, 1'b0);
    v1 = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    last_s = '0;
    last_c = '0;
    #1;
    check("midrst_sum", s1, 8'h00);
    check("midrst_carry", c1, 8'h00);
    check("midrst_out_valid", ov1, 1'b0);
    check("midrst_cnt", cnt1, 16'd0);
    check("midrst_sat_cnt", cnt2, 2'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    op1(1'b0, 8'($urandom), 8'($urandom), 1'b0);
    for (int k = 0; k < 20; k++) begin
      op1($urandom_range(0, 1) != 0, 8'($urandom), 8'($urandom), 1'b0);
    end
    op1(1'b0, 8'h00, 8'h00, 1'b0);
    op1(1'b0, 8'h00, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
